exec_alu_mc: RTL and testbench
==============================

Name: exec_alu_mc

Overview:
- Next-generation execute-stage ALU.
- Generalised to WIDTH bits, with a registered valid/ready output and a held NZCV status register.
- Adds an iterative multi-cycle multiplier (MUL, MLA) that stalls the pipeline through in_ready.
- Sits between the ID/EX register and the EX/MEM register. The status register feeds the condition-check logic.

Parameters:
- WIDTH, 32: datapath width; must be ≥ 8.
- MUL_STEP, 1: multiplier bits retired per cycle; must be 1, 2 or 4 and divide WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit can accept an operation this cycle.
- cmd  in  4  execute command.
- val1  in  WIDTH  operand 1 (Rn).
- val2  in  WIDTH  operand 2 (shifter output).
- val3  in  WIDTH  accumulate operand (MLA only).
- s_update  in  1  S bit: write flags on completion.
- out_valid  out  1  res valid.
- out_ready  in  1  downstream accepts res.
- res  out  WIDTH  result, held while out_valid && !out_ready.
- sr  out  4  status register {Z,C,N,V}.
- illegal  out  1  one-cycle pulse concurrent with out_valid for an undefined cmd.

Behaviour:
- Reset (async, rst_n low): state=IDLE, out_valid=0, res=0, sr=0000, illegal=0, counter=0.
  - Reset mid-multiply aborts it; no result or flag write occurs.
- Command encodings:
  - MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, CMP 1100, TST 1110.
  - MEM 1010: address = val1+val2, flags never written.
  - New: MUL 1011, MLA 1101.
  - Any other code is undefined.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Accept = in_valid && in_ready.
  - Output is consumed when out_valid && out_ready.
  - Accept and consume may occur in the same cycle: full throughput of 1 op/cycle for single-cycle ops.
- Latency:
  - Single-cycle ops: res/out_valid registered on the cycle after accept.
  - MUL/MLA: state IDLE -> MUL for WIDTH/MUL_STEP cycles (counter counts down to 0), then -> IDLE with out_valid=1. Total accept-to-out_valid latency is WIDTH/MUL_STEP+1 cycles. in_ready=0 throughout MUL.
- Carry-in: ADC/SBC take carry from sr.C, i.e. the held flag, not a port.
  - If the previous op updates C and is accepted back-to-back, its new C is used (internal forward).
- Arithmetic, computed in WIDTH+1 bits:
  - ADD: C = carry-out; V = (a[W-1]==b[W-1]) && (r[W-1]!=a[W-1]).
  - ADC: as ADD with +C.
  - SUB/CMP: r = a + ~b + 1; C = NOT borrow (ARM convention); V = (a[W-1]!=b[W-1]) && (r[W-1]!=a[W-1]).
  - SBC: r = a + ~b + C (borrow = !C).
  - MUL: r = low WIDTH bits of val1*val2.
  - MLA: r = low WIDTH bits of val1*val2 + val3.
- Flags:
  - N = r[W-1]; Z = (r==0).
  - Logic ops, MOV, MVN, MUL and MLA write C=0, V=0.
  - Flags are written at result-register load when s_update=1, or always for CMP/TST.
  - CMP/TST still produce res (the discarded value) with out_valid=1.
- Undefined cmd: res=0, sr unchanged, out_valid=1, illegal=1 for that output cycle.
- Stall: while out_valid && !out_ready, res, sr, illegal and state hold. A finished multiply waits in IDLE with out_valid=1.
- Wrap-around: 0xFFFF_FFFF+1 gives r=0, Z=1, C=1, V=0. 0x7FFF_FFFF+1 gives N=1, V=1.

Decomposition:
- Package exec_alu_pkg holds:
  - cmd localparams (including MUL/MLA);
  - flag bit indices SR_Z=3, SR_C=2, SR_N=1, SR_V=0;
  - state encoding IDLE/MUL.
- Sub-module mul_iter (parametrised WIDTH, MUL_STEP): shift-add multiplier with start/done and accumulator preload of val3 (0 for MUL). The top holds the handshake, single-cycle datapath and sr.

Test Plan:
- Reset then ADD with val1=0xFFFF_FFFF, val2=1, s_update=1, out_ready=1 -> next cycle out_valid=1, res=0, sr=1100 (Z,C).
- Back-to-back SUB with val1=5, val2=7, S=1; then SBC with val1=0, val2=0, S=1 -> res 0xFFFF_FFFE with C=0; SBC uses the forwarded C=0 -> res 0xFFFF_FFFF, sr=0010, one result per cycle.
- MLA with val1=3, val2=0xFFFF_FFFF, val3=5, WIDTH=32, MUL_STEP=1 -> in_ready=0 for 32 cycles, out_valid on cycle 33 after accept, res=2, sr unchanged (S=0).
- Hold out_ready=0 for 3 cycles after a MOV val2=0xA5 -> res=0xA5 stable, in_ready=0, next op not accepted until out_ready=1.
- cmd=0000 -> out_valid with res=0, illegal=1 for one cycle, sr unchanged.
- Assert rst_n=0 during cycle 10 of a MUL -> out_valid, res, sr and illegal all 0 immediately. After release, in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/exec_alu_pkg.sv
// Shared definitions for the execute-stage ALU: command codes, status flag
// positions and the control state encoding.
package exec_alu_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_MEM = 4'b1010;
    localparam logic [3:0] CMD_MUL = 4'b1011;
    localparam logic [3:0] CMD_CMP = 4'b1100;
    localparam logic [3:0] CMD_MLA = 4'b1101;
    localparam logic [3:0] CMD_TST = 4'b1110;

    // Bit positions inside the {Z,C,N,V} status register.
    localparam int SR_Z = 3;
    localparam int SR_C = 2;
    localparam int SR_N = 1;
    localparam int SR_V = 0;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

    // True for commands handled by the iterative multiplier.
    function automatic logic cmd_is_mul(input logic [3:0] c);
        return (c == CMD_MUL) || (c == CMD_MLA);
    endfunction

endpackage

// File: rtl/exec_alu_mc_mul.sv
// Iterative shift-add multiplier. 'start' loads the operands and the
// accumulator preload (val3 for MLA, zero for MUL); MUL_STEP multiplier
// bits are retired per cycle, and 'done' is raised for one cycle once all
// bits are consumed, with the low WIDTH bits of the result on 'prod'.
module mul_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] acc_init,
    output logic             done,
    output logic [WIDTH-1:0] prod
);

    localparam int STEPS = WIDTH / MUL_STEP;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] STEPS_C = CNT_W'(STEPS);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] partial_s;

    // Partial product of this step plus load / iterate / finish sequencing.
    always_comb begin
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        partial_s = '0;
        for (int j = 0; j < MUL_STEP; j++) begin
            partial_s = partial_s + (mplier_q[j] ? (mcand_q << j) : {WIDTH{1'b0}});
        end
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = STEPS_C;
            acc_d    = acc_init;
            mcand_d  = op_a;
            mplier_d = op_b;
        end else if (busy_q && (cnt_q != {CNT_W{1'b0}})) begin
            acc_d    = acc_q + partial_s;
            mcand_d  = mcand_q << MUL_STEP;
            mplier_d = mplier_q >> MUL_STEP;
            cnt_d    = cnt_q - CNT_W'(1);
        end else if (busy_q) begin
            busy_d = 1'b0;
        end else begin
            busy_d = 1'b0;
        end
    end

    // Multiplier state registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign done = busy_q && (cnt_q == {CNT_W{1'b0}});
    assign prod = acc_q;

endmodule

// File: rtl/exec_alu_mc.sv
// Execute-stage ALU with valid/ready handshake, held {Z,C,N,V} status
// register and a stalling iterative multiplier for MUL/MLA.
module exec_alu_mc
    import exec_alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       cmd,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic [WIDTH-1:0] val3,
    input  logic             s_update,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       sr,
    output logic             illegal
);

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [3:0]       sr_q, sr_d;
    logic             illegal_q, illegal_d;
    logic             s_mul_q, s_mul_d;

    logic             accept_s, consume_s, is_mul_s, mul_done_s;
    logic [WIDTH-1:0] mul_prod_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_c_s, alu_v_s, alu_undef_s, alu_wr_s, cin_s;
    logic [3:0]       alu_flags_s, mul_flags_s;

    assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept_s  = in_valid && in_ready;
    assign consume_s = out_valid_q && out_ready;
    assign is_mul_s  = cmd_is_mul(cmd);

    mul_iter #(.WIDTH(WIDTH), .MUL_STEP(MUL_STEP)) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (accept_s && is_mul_s),
        .op_a     (val1),
        .op_b     (val2),
        .acc_init ((cmd == CMD_MLA) ? val3 : {WIDTH{1'b0}}),
        .done     (mul_done_s),
        .prod     (mul_prod_s)
    );

    // Single-cycle datapath; carry-in comes from the held C flag, which
    // already holds a back-to-back predecessor's C since flags load with res.
    always_comb begin
        cin_s       = sr_q[SR_C];
        sum_s       = '0;
        alu_res_s   = '0;
        alu_c_s     = 1'b0;
        alu_v_s     = 1'b0;
        alu_undef_s = 1'b0;
        alu_wr_s    = s_update;
        case (cmd)
            CMD_MOV: alu_res_s = val2;
            CMD_MVN: alu_res_s = ~val2;
            CMD_ADD, CMD_ADC: begin
                sum_s     = {1'b0, val1} + {1'b0, val2}
                          + ((cmd == CMD_ADC) ? {{WIDTH{1'b0}}, cin_s} : {(WIDTH+1){1'b0}});
                alu_res_s = sum_s[WIDTH-1:0];
                alu_c_s   = sum_s[WIDTH];
                alu_v_s   = (val1[WIDTH-1] == val2[WIDTH-1]) && (sum_s[WIDTH-1] != val1[WIDTH-1]);
            end
            CMD_SUB, CMD_CMP, CMD_SBC: begin
                sum_s     = {1'b0, val1} + {1'b0, ~val2}
                          + ((cmd == CMD_SBC) ? {{WIDTH{1'b0}}, cin_s} : (WIDTH+1)'(1));
                alu_res_s = sum_s[WIDTH-1:0];
                alu_c_s   = sum_s[WIDTH];
                alu_v_s   = (val1[WIDTH-1] != val2[WIDTH-1]) && (sum_s[WIDTH-1] != val1[WIDTH-1]);
                alu_wr_s  = s_update || (cmd == CMD_CMP);
            end
            CMD_AND: alu_res_s = val1 & val2;
            CMD_TST: begin
                alu_res_s = val1 & val2;
                alu_wr_s  = 1'b1;
            end
            CMD_ORR: alu_res_s = val1 | val2;
            CMD_EOR: alu_res_s = val1 ^ val2;
            CMD_MEM: begin
                alu_res_s = val1 + val2;
                alu_wr_s  = 1'b0;
            end
            CMD_MUL, CMD_MLA: alu_wr_s = 1'b0;
            default: begin
                alu_undef_s = 1'b1;
                alu_wr_s    = 1'b0;
            end
        endcase
        alu_flags_s       = 4'b0000;
        alu_flags_s[SR_Z] = (alu_res_s == {WIDTH{1'b0}});
        alu_flags_s[SR_C] = alu_c_s;
        alu_flags_s[SR_N] = alu_res_s[WIDTH-1];
        alu_flags_s[SR_V] = alu_v_s;
        mul_flags_s       = 4'b0000;
        mul_flags_s[SR_Z] = (mul_prod_s == {WIDTH{1'b0}});
        mul_flags_s[SR_N] = mul_prod_s[WIDTH-1];
    end

    // Control FSM and result/status register load; everything holds while
    // the output is stalled.
    always_comb begin
        state_d     = state_q;
        res_d       = res_q;
        sr_d        = sr_q;
        s_mul_d     = s_mul_q;
        if (consume_s) begin
            out_valid_d = 1'b0;
            illegal_d   = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
            illegal_d   = illegal_q;
        end
        case (state_q)
            IDLE: begin
                if (accept_s && is_mul_s) begin
                    state_d = MUL;
                    s_mul_d = s_update;
                end else if (accept_s) begin
                    out_valid_d = 1'b1;
                    res_d       = alu_res_s;
                    illegal_d   = alu_undef_s;
                    sr_d        = alu_wr_s ? alu_flags_s : sr_q;
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                if (mul_done_s) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    res_d       = mul_prod_s;
                    illegal_d   = 1'b0;
                    sr_d        = s_mul_q ? mul_flags_s : sr_q;
                end else begin
                    state_d = MUL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            sr_q        <= 4'b0000;
            illegal_q   <= 1'b0;
            s_mul_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            sr_q        <= sr_d;
            illegal_q   <= illegal_d;
            s_mul_q     <= s_mul_d;
        end
    end

    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign sr        = sr_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_exec_alu_mc.sv
// Directed self-checking bench for exec_alu_mc (WIDTH=32, MUL_STEP=1).
module tb_exec_alu_mc;

    logic        clk, rst_n, in_valid, in_ready, s_update;
    logic        out_valid, out_ready, illegal;
    logic [3:0]  cmd, sr;
    logic [31:0] val1, val2, val3, res;
    int          total = 0;
    int          bad   = 0;
    int          cyc, rhi;

    exec_alu_mc #(.WIDTH(32), .MUL_STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .cmd(cmd), .val1(val1), .val2(val2), .val3(val3), .s_update(s_update),
        .out_valid(out_valid), .out_ready(out_ready), .res(res), .sr(sr),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] d, input logic s);
        in_valid = 1'b1;
        cmd      = c;
        val1     = a;
        val2     = b;
        val3     = d;
        s_update = s;
    endtask

    // Waits (bounded) for out_valid; reports cycles waited and in_ready-high samples.
    task automatic wait_out(output int n, output int hi);
        n  = 0;
        hi = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            if (in_ready) hi++;
            tick();
            n++;
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] r, input logic [3:0] s);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_res"}, res, r);
        chk({tag, "_sr"}, {28'd0, sr}, {28'd0, s});
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cmd = 4'd0; val1 = 32'd0; val2 = 32'd0; val3 = 32'd0; s_update = 1'b0;
        #3;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_res", res, 32'd0);
        chk("rst_sr", {28'd0, sr}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        #4 rst_n = 1'b1;

        issue(4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1); tick();
        chk_out("add_wrap", 32'd0, 4'b1100);
        issue(4'b0100, 32'd5, 32'd7, 32'd0, 1'b1); tick();
        chk_out("sub", 32'hFFFF_FFFE, 4'b0010);
        issue(4'b0101, 32'd0, 32'd0, 32'd0, 1'b1); tick();
        chk_out("sbc_fwd", 32'hFFFF_FFFF, 4'b0010);
        issue(4'b0010, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b1); tick();
        chk_out("add_ovf", 32'h8000_0000, 4'b0011);
        issue(4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1); tick();
        chk_out("add_c", 32'd0, 4'b1100);
        issue(4'b0011, 32'd1, 32'd2, 32'd0, 1'b1); tick();
        chk_out("adc", 32'd4, 4'b0000);
        issue(4'b1100, 32'd3, 32'd3, 32'd0, 1'b0); tick();
        chk_out("cmp", 32'd0, 4'b1100);
        issue(4'b0010, 32'd1, 32'd1, 32'd0, 1'b0); tick();
        chk_out("add_nos", 32'd2, 4'b1100);
        issue(4'b1110, 32'hF0, 32'h0F, 32'd0, 1'b0); tick();
        chk_out("tst", 32'd0, 4'b1000);
        issue(4'b1010, 32'h100, 32'h20, 32'd0, 1'b1); tick();
        chk_out("mem", 32'h120, 4'b1000);
        issue(4'b0111, 32'hF0, 32'h0F, 32'd0, 1'b1); tick();
        chk_out("orr", 32'hFF, 4'b0000);
        issue(4'b1001, 32'd0, 32'd0, 32'd0, 1'b1); tick();
        chk_out("mvn", 32'hFFFF_FFFF, 4'b0010);
        issue(4'b1000, 32'hFF, 32'hFF, 32'd0, 1'b1); tick();
        chk_out("eor", 32'd0, 4'b1000);
        issue(4'b0000, 32'h12, 32'h34, 32'd0, 1'b1); tick();
        chk_out("undef", 32'd0, 4'b1000);
        chk("undef_illegal", {31'd0, illegal}, 32'd1);
        in_valid = 1'b0; tick();
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_illegal", {31'd0, illegal}, 32'd0);

        // Output stall: MOV result must hold while out_ready is low.
        issue(4'b0001, 32'd0, 32'hA5, 32'd0, 1'b0); tick();
        chk_out("mov", 32'hA5, 4'b1000);
        out_ready = 1'b0;
        issue(4'b0010, 32'd1, 32'd1, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_res", res, 32'hA5);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1; #1;
        chk("unstall_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk_out("after_stall", 32'd2, 4'b1000);

        // MLA: 3*0xFFFFFFFF+5 mod 2^32 = 2, flags untouched.
        issue(4'b1101, 32'd3, 32'hFFFF_FFFF, 32'd5, 1'b0); tick();
        in_valid = 1'b0;
        wait_out(cyc, rhi);
        chk("mla_latency", cyc, 32'd33);
        chk("mla_in_ready_hi", rhi, 32'd0);
        chk_out("mla", 32'd2, 4'b1000);
        chk("mla_illegal", {31'd0, illegal}, 32'd0);

        issue(4'b1011, 32'h12345, 32'h100, 32'hDEAD, 1'b1); tick();
        in_valid = 1'b0;
        wait_out(cyc, rhi);
        chk("mul_latency", cyc, 32'd33);
        chk_out("mul", 32'h0123_4500, 4'b0000);

        // Reset in the middle of a multiply.
        issue(4'b0100, 32'd9, 32'd3, 32'd0, 1'b1); tick();
        chk_out("sub_pre", 32'd6, 4'b0100);
        issue(4'b1011, 32'h55, 32'd3, 32'd0, 1'b1); tick();
        in_valid = 1'b0;
        repeat (10) tick();
        chk("mid_mul_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0; #1;
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_res", res, 32'd0);
        chk("mrst_sr", {28'd0, sr}, 32'd0);
        chk("mrst_illegal", {31'd0, illegal}, 32'd0);
        #3 rst_n = 1'b1; #1;
        chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid !== 1'b0) cyc++;
        end
        chk("no_stale_result", cyc, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
